// File: rtl/vga_rd_ctrl.sv
// vga_rd_ctrl: VGA 640x480 timing that shows a windowed 1-bit frame from the reader bank of a ping-pong buffer.
// Bank swaps happen only at frame end, so the picture never tears.
module vga_rd_ctrl #(
  parameter int RD_LAT = 2,
  parameter int WIN_X0 = 160,
  parameter int WIN_Y0 = 120,
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 200,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_end,
  input  logic        rd_data,
  output logic [15:0] rd_addr,
  output logic        rd_en,
  output logic        rd_end,
  output logic        rd_addr_sel,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [15:0] vga_rgb
);
  localparam logic [9:0]  H_LAST = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HS_B   = 10'(H_ACT + H_FP);
  localparam logic [9:0]  HS_E   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  VS_B   = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_E   = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0]  X_B    = 10'(WIN_X0);
  localparam logic [9:0]  X_E    = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0]  Y_B    = 10'(WIN_Y0);
  localparam logic [9:0]  Y_E    = 10'(WIN_Y0 + WIN_H);
  localparam logic [15:0] A_LAST = 16'(WIN_W * WIN_H - 1);
  typedef enum logic {WAIT_FIRST, SHOW} state_t;
  state_t r_state, w_state_nxt;
  logic [9:0]  r_h, r_v;
  logic        r_sel, r_hs, r_vs;
  logic [15:0] r_addr, r_rgb;
  logic [RD_LAT:0][2:0] r_pipe;
  logic w_h_end, w_frame_end, w_swap, w_in_win, w_en, w_hs, w_vs;
  always_comb begin
    w_h_end     = r_h == H_LAST;
    w_frame_end = w_h_end && r_v == V_LAST;
    w_swap      = w_frame_end && wr_end;
    w_in_win    = r_h >= X_B && r_h < X_E && r_v >= Y_B && r_v < Y_E;
    w_en        = r_state == SHOW && w_in_win;
    w_hs        = !(r_h >= HS_B && r_h < HS_E);
    w_vs        = !(r_v >= VS_B && r_v < VS_E);
    w_state_nxt = w_swap ? SHOW : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= WAIT_FIRST;
    else     r_state <= w_state_nxt;
  // r_pipe[0] carries {rd_en, hs, vs}; the sync bits ride along with the read so they line up with rd_data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_h    <= '0;
      r_v    <= '0;
      r_sel  <= 1'b0;
      r_addr <= '0;
      r_pipe <= {(RD_LAT + 1){3'b011}};
      r_rgb  <= '0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
    end else begin
      r_h    <= w_h_end ? '0 : r_h + 10'd1;
      r_v    <= w_h_end ? (r_v == V_LAST ? '0 : r_v + 10'd1) : r_v;
      r_sel  <= r_sel ^ w_swap;
      r_addr <= w_frame_end ? '0 : (rd_en && r_addr != A_LAST) ? r_addr + 16'd1 : r_addr;
      r_pipe[0] <= {w_en, w_hs, w_vs};
      for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_rgb  <= (r_pipe[RD_LAT][2] && rd_data) ? 16'hFFFF : 16'h0000;
      r_hs   <= r_pipe[RD_LAT][1];
      r_vs   <= r_pipe[RD_LAT][0];
    end
  assign rd_en       = r_pipe[0][2];
  assign rd_addr     = r_addr;
  assign rd_end      = w_swap;
  assign rd_addr_sel = r_sel;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_rgb     = r_rgb;
endmodule

// File: tb/tb_vga_rd_ctrl.sv
// tb_vga_rd_ctrl: scoreboard bench for vga_rd_ctrl on a shrunken raster so whole frames fit a short run.
module tb_vga_rd_ctrl;
  localparam int RD_LAT = 2;
  localparam int X0 = 4, Y0 = 3, W = 10, H = 8;
  localparam int HA = 24, HF = 4, HS = 6, HB = 6;
  localparam int VA = 16, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, F = HT * VT;
  localparam int L = RD_LAT + 2;
  logic clk = 1'b0, rst = 1'b1, wr_end = 1'b0, rd_data;
  logic [15:0] rd_addr, vga_rgb;
  logic rd_en, rd_end, rd_addr_sel, vga_hs, vga_vs;
  int total = 0, bad = 0;
  int mh, mv, en_cnt, hs_cnt, vs_cnt, end_cnt, fcyc;
  bit show, msel, tie1 = 1'b1;
  logic [1:0] mem_q = 2'b11;
  typedef struct packed {logic en; logic [15:0] addr;} rd_t;
  typedef struct packed {logic [15:0] rgb; logic hs; logic vs;} px_t;
  rd_t q_rd[$];
  px_t q_px[$];
  vga_rd_ctrl #(.RD_LAT(RD_LAT), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst(rst), .wr_end(wr_end), .rd_data(rd_data), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_end(rd_end), .rd_addr_sel(rd_addr_sel),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb));
  always #5 clk = ~clk;
  // buffer model: two-cycle read, returns 1 when not enabled so unmasked garbage shows up
  always @(posedge clk) mem_q <= {mem_q[0], tie1 | !rd_en | (rd_addr[0] ^ rd_addr[2])};
  assign rd_data = mem_q[1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask
  function automatic logic in_win(int h, int v);
    return h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + H;
  endfunction
  function automatic logic [15:0] exp_addr(int h, int v);
    int r, c, n;
    if (h == HT - 1 && v == VT - 1) return 16'd0;
    r = v < Y0 ? 0 : (v >= Y0 + H ? H : v - Y0);
    c = (v >= Y0 && v < Y0 + H) ? (h < X0 ? 0 : (h >= X0 + W ? W : h - X0)) : 0;
    n = r * W + c;
    return 16'(n > W * H - 1 ? W * H - 1 : n);
  endfunction
  task automatic chk_reset();
    chk("rst_rd_en", 32'(rd_en), 32'(0));
    chk("rst_rd_addr", 32'(rd_addr), 32'(0));
    chk("rst_rd_end", 32'(rd_end), 32'(0));
    chk("rst_sel", 32'(rd_addr_sel), 32'(0));
    chk("rst_hs", 32'(vga_hs), 32'(1));
    chk("rst_vs", 32'(vga_vs), 32'(1));
    chk("rst_rgb", 32'(vga_rgb), 32'(0));
  endtask
  task automatic reset_model();
    mh = 0; mv = 0; show = 1'b0; msel = 1'b0;
    en_cnt = 0; hs_cnt = 0; vs_cnt = 0; end_cnt = 0; fcyc = 0;
    q_rd.delete();
    q_px.delete();
    repeat (L - 1) q_px.push_back('{rgb: 16'h0000, hs: 1'b1, vs: 1'b1});
  endtask
  task automatic step();
    logic fe, win;
    logic [15:0] a;
    rd_t r;
    px_t p;
    fe  = (mh == HT - 1 && mv == VT - 1);
    win = show && in_win(mh, mv);
    a   = show ? exp_addr(mh, mv) : 16'd0;
    chk("rd_end", 32'(rd_end), 32'(fe && wr_end));
    end_cnt += int'(rd_end);
    q_rd.push_back('{en: win, addr: a});
    q_px.push_back('{rgb: (win && (tie1 || (a[0] ^ a[2]))) ? 16'hFFFF : 16'h0000,
                     hs: !(mh >= HA + HF && mh < HA + HF + HS),
                     vs: !(mv >= VA + VF && mv < VA + VF + VS)});
    @(posedge clk); #1;
    r = q_rd.pop_front();
    p = q_px.pop_front();
    chk("rd_en", 32'(rd_en), 32'(r.en));
    chk("rd_addr", 32'(rd_addr), 32'(r.addr));
    chk("vga_rgb", 32'(vga_rgb), 32'(p.rgb));
    chk("vga_hs", 32'(vga_hs), 32'(p.hs));
    chk("vga_vs", 32'(vga_vs), 32'(p.vs));
    en_cnt += int'(rd_en);
    hs_cnt += int'(!vga_hs);
    vs_cnt += int'(!vga_vs);
    fcyc++;
    if (fe) begin
      if (fcyc == F) begin
        chk("rd_en_per_frame", 32'(en_cnt), 32'(show ? W * H : 0));
        chk("hs_low_per_frame", 32'(hs_cnt), 32'(VT * HS));
        chk("vs_low_per_frame", 32'(vs_cnt), 32'(VS * HT));
        chk("rd_end_per_frame", 32'(end_cnt), 32'(wr_end ? 1 : 0));
      end
      en_cnt = 0; hs_cnt = 0; vs_cnt = 0; end_cnt = 0; fcyc = 0;
      if (wr_end) begin
        show = 1'b1;
        msel = ~msel;
      end
    end
    mh = (mh == HT - 1) ? 0 : mh + 1;
    if (mh == 0) mv = (mv == VT - 1) ? 0 : mv + 1;
    chk("rd_addr_sel", 32'(rd_addr_sel), 32'(msel));
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst = 1'b0;
    reset_model();
    run(2 * F);
    wr_end = 1'b1;
    run(F);
    run(F);
    tie1 = 1'b0;
    wr_end = 1'b0;
    run(F);
    wr_end = 1'b1;
    run(F);
    run((Y0 + 3) * HT + X0 + 2);
    #2 rst = 1'b1;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset();
    rst = 1'b0;
    wr_end = 1'b0;
    reset_model();
    run(F + HT);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_rd_ctrl.md
VGA_RD_CTRL -- requirements
Module: vga_rd_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning buffer read latency in cycles from sampled rd_en/rd_addr to valid rd_data.
REQ-002 SHALL have parameters WIN_X0=160, WIN_Y0=120, WIN_W=320, WIN_H=200, meaning the display window position and size in pixels.
REQ-003 SHALL have port clk, input, 1 bit: the single pixel clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_end, input, 1 bit: writer has a complete frame in its bank; held until acknowledged.
REQ-006 SHALL have port rd_data, input, 1 bit: binary pixel from the read bank.
REQ-007 SHALL have port rd_addr, output, 16 bits: read address into the buffer.
REQ-008 SHALL have port rd_en, output, 1 bit: buffer read enable.
REQ-009 SHALL have port rd_end, output, 1 bit: one-cycle acknowledge of wr_end (bank swap).
REQ-010 SHALL have port rd_addr_sel, output, 1 bit: bank select (0: writer uses bank 0, reader uses bank 1; 1: reverse).
REQ-011 SHALL have ports vga_hs and vga_vs, output, 1 bit each: sync, active low.
REQ-012 SHALL have port vga_rgb, output, 16 bits: RGB565 pixel.

Function
REQ-013 SHALL count h_cnt 0..799 and wrap to 0, and SHALL advance v_cnt 0..524 on each h_cnt wrap, wrapping to 0.
REQ-014 SHALL treat h_cnt 0..639 as active, 640..655 as front porch, 656..751 as sync (low), and 752..799 as back porch.
REQ-015 SHALL treat v_cnt 0..479 as active, 480..489 as front porch, 490..491 as sync (low), and 492..524 as back porch.
REQ-016 SHALL define the window as WIN_X0<=h_cnt<WIN_X0+WIN_W and WIN_Y0<=v_cnt<WIN_Y0+WIN_H.
REQ-017 SHALL define two states: WAIT_FIRST (no valid frame yet) and SHOW.
REQ-018 SHALL define the frame-end cycle as h_cnt=799 and v_cnt=524.
REQ-019 SHALL, on the frame-end cycle with wr_end=1, assert rd_end for exactly that cycle, toggle rd_addr_sel on the next cycle, and move WAIT_FIRST->SHOW (SHOW stays SHOW).
REQ-020 SHALL, on the frame-end cycle with wr_end=0, keep rd_end=0, rd_addr_sel and state unchanged; the same bank is redisplayed.
REQ-021 SHALL keep rd_end low on every cycle other than a qualifying frame-end cycle, even if wr_end stays high.
REQ-022 SHALL never change rd_addr_sel except through REQ-019, and never mid-frame.
REQ-023 SHALL register rd_en=1 one cycle after each counter position inside the window while in SHOW, and 0 otherwise.
REQ-024 SHALL, in WAIT_FIRST, hold rd_en at 0.
REQ-025 SHALL clear rd_addr to 0 at frame end and increment it by 1 after each rd_en cycle, so reads are 0..WIN_W*WIN_H-1 (0..63999) in raster order.
REQ-026 SHALL never advance rd_addr beyond WIN_W*WIN_H-1, and SHALL not wrap it mid-frame.
REQ-027 SHALL drive vga_rgb, vga_hs and vga_vs for counter position (x,y) exactly RD_LAT+2 cycles after the counters hold (x,y), with hs/vs delayed identically to the pixel.
REQ-028 SHALL drive vga_rgb as 16'hFFFF when rd_data=1 and 16'h0000 when rd_data=0 for pixels inside the window in SHOW.
REQ-029 SHALL drive vga_rgb as 16'h0000 for active pixels outside the window, for all pixels in WAIT_FIRST, and during blanking.

Reset
REQ-030 SHALL, while rst=1 (asynchronous), force h_cnt=0, v_cnt=0, state=WAIT_FIRST, rd_addr_sel=0, rd_en=0, rd_addr=0, rd_end=0, vga_hs=1, vga_vs=1, vga_rgb=0, and clear all delay pipelines.
REQ-031 SHALL, on rst asserted mid-frame, abandon the frame, and on release restart at h_cnt=0, v_cnt=0 with no rd_end emitted.

Verification
REQ-032 Bench SHALL cover: reset release with wr_end=0 for 2 frames -> rd_en never 1, vga_rgb always 0, vga_hs low 96 cycles per 800, vga_vs low 1600 cycles per 420000.
REQ-033 Bench SHALL cover: wr_end=1 held -> rd_end high exactly 1 cycle at h=799/v=524, rd_addr_sel 0->1 next cycle, 1->0 at the following frame end.
REQ-034 Bench SHALL cover: SHOW frame -> exactly 64000 rd_en cycles, first rd_addr=0 at (160,120), last rd_addr=63999 at (479,319).
REQ-035 Bench SHALL cover: rd_data tied 1 in SHOW -> vga_rgb=FFFF for window pixels only, 0 elsewhere, with RD_LAT+2 alignment relative to hs.
REQ-036 Bench SHALL cover: wr_end=0 at a SHOW frame end -> no rd_end, rd_addr_sel unchanged, rd_addr sequence repeats.
REQ-037 Bench SHALL cover: rst pulse at v_cnt=200 -> all outputs at reset values immediately, state WAIT_FIRST, rd_addr_sel=0.
